// File: rtl/pc_pkg.sv
// Shared definitions for the Thistle program-counter sequencer:
// op encodings and op width used by the control unit and the PC block.
package pc_pkg;

    localparam int PC_OP_W = 3;

    localparam logic [PC_OP_W-1:0] PC_HOLD = 3'b000;
    localparam logic [PC_OP_W-1:0] PC_INC  = 3'b001;
    localparam logic [PC_OP_W-1:0] PC_DEC  = 3'b010;
    localparam logic [PC_OP_W-1:0] PC_LOAD = 3'b011;
    localparam logic [PC_OP_W-1:0] PC_REL  = 3'b100;
    localparam logic [PC_OP_W-1:0] PC_CALL = 3'b101;
    localparam logic [PC_OP_W-1:0] PC_RET  = 3'b110;

endpackage

// File: rtl/pc_seq_if.sv
// Control-unit to program-counter link: one op per cycle in, PC and stack status out.
// Handshake: pc_en qualifies pc_op/pc_in/err_clr is not gated by it; there is no
// ready, the PC block accepts every qualified op on the clock edge it is presented.
interface pc_seq_if #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
);
    import pc_pkg::*;

    localparam int SP_W = $clog2(STACK_DEPTH) + 1;

    logic               pc_en;
    logic [PC_OP_W-1:0] pc_op;
    logic [ADDR_W-1:0]  pc_in;
    logic               err_clr;
    logic [ADDR_W-1:0]  pc_out;
    logic [SP_W-1:0]    sp_out;
    logic               stack_full;
    logic               stack_empty;
    logic               stack_err;

    modport master (
        output pc_en, pc_op, pc_in, err_clr,
        input  pc_out, sp_out, stack_full, stack_empty, stack_err
    );

    modport slave (
        input  pc_en, pc_op, pc_in, err_clr,
        output pc_out, sp_out, stack_full, stack_empty, stack_err
    );

endinterface

// File: rtl/pc_ret_stack.sv
// Register-array LIFO of return addresses. Push when full and pop when empty
// are silently ignored; the caller decides whether that is an error.
module pc_ret_stack #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  logic                             pop,
    input  logic [ADDR_W-1:0]                push_data,
    output logic [ADDR_W-1:0]                top_data,
    output logic [$clog2(STACK_DEPTH):0]     sp,
    output logic                             full,
    output logic                             empty
);
    localparam int IW   = $clog2(STACK_DEPTH);
    localparam int SP_W = IW + 1;

    logic [ADDR_W-1:0] entries [STACK_DEPTH];
    logic [IW-1:0]     wr_idx;
    logic [IW-1:0]     top_idx;

    // sp counts occupied slots, so the next free slot is sp and the top is sp-1.
    assign wr_idx   = sp[IW-1:0];
    assign top_idx  = sp[IW-1:0] - IW'(1);
    assign top_data = entries[top_idx];
    assign full     = (sp == SP_W'(STACK_DEPTH));
    assign empty    = (sp == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (push && !full) begin
            entries[wr_idx] <= push_data;
            sp              <= sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp <= sp - SP_W'(1);
        end
    end

endmodule

// File: rtl/pc_seq.sv
// Thistle program counter: next-PC mux, relative adder, call/return stack
// and a sticky overflow/underflow flag. pc_out is purely registered.
module pc_seq
    import pc_pkg::*;
#(
    parameter int                ADDR_W      = 8,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
    input logic     clk,
    input logic     rst,
    pc_seq_if.slave bus
);
    localparam int SP_W = $clog2(STACK_DEPTH) + 1;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] push_data;
    logic [ADDR_W-1:0] top_data;
    logic [SP_W-1:0]   sp;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              err_set;
    logic              err_q;

    assign push_data = pc_q + ADDR_W'(1);

    always_comb begin
        pc_d    = pc_q;
        push    = 1'b0;
        pop     = 1'b0;
        err_set = 1'b0;
        if (bus.pc_en) begin
            case (bus.pc_op)
                PC_INC:  pc_d = pc_q + ADDR_W'(1);
                PC_DEC:  pc_d = pc_q - ADDR_W'(1);
                PC_LOAD: pc_d = bus.pc_in;
                // Offset is already ADDR_W wide, so its sign extension is itself;
                // the modular add gives the signed relative branch.
                PC_REL:  pc_d = pc_q + bus.pc_in;
                PC_CALL: begin
                    if (full) begin
                        err_set = 1'b1;
                    end else begin
                        push = 1'b1;
                        pc_d = bus.pc_in;
                    end
                end
                PC_RET: begin
                    if (empty) begin
                        err_set = 1'b1;
                    end else begin
                        pop  = 1'b1;
                        pc_d = top_data;
                    end
                end
                default: pc_d = pc_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RESET_VEC;
            err_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            // A set event in the same cycle as err_clr keeps the flag raised.
            if (err_set) begin
                err_q <= 1'b1;
            end else if (bus.err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    pc_ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .top_data  (top_data),
        .sp        (sp),
        .full      (full),
        .empty     (empty)
    );

    assign bus.pc_out      = pc_q;
    assign bus.sp_out      = sp;
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
    assign bus.stack_err   = err_q;

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq (ADDR_W=8, STACK_DEPTH=4): each step queues its
// expected PC/stack status, applies one op, and checks one cycle later.
module tb_pc_seq;
    import pc_pkg::*;

    localparam int ADDR_W      = 8;
    localparam int STACK_DEPTH = 4;
    localparam int W           = ADDR_W + 3 + 3;

    logic clk;
    logic rst;

    logic [W-1:0] exp_q[$];
    int vectors;
    int miscompares;

    pc_seq_if #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) bus ();

    pc_seq #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH),
        .RESET_VEC   (8'h00)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] pack_exp(input logic [7:0] e_pc, input logic [2:0] e_sp,
                                              input logic e_err);
        return {e_pc, e_sp, (e_sp == 3'd4), (e_sp == 3'd0), e_err};
    endfunction

    // scoreboard
    task automatic compare(input string tag);
        logic [W-1:0] exp_v;
        logic [W-1:0] obs_v;
        exp_v = exp_q.pop_front();
        obs_v = {bus.pc_out, bus.sp_out, bus.stack_full, bus.stack_empty, bus.stack_err};
        vectors++;
        assert (obs_v === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed pc=%h sp=%0d full=%b empty=%b err=%b, expected pc=%h sp=%0d full=%b empty=%b err=%b",
                   tag, obs_v[13:6], obs_v[5:3], obs_v[2], obs_v[1], obs_v[0],
                   exp_v[13:6], exp_v[5:3], exp_v[2], exp_v[1], exp_v[0]);
        end
    endtask

    // driver
    task automatic step(input string tag, input logic en, input logic [2:0] op,
                        input logic [7:0] in, input logic clr,
                        input logic [7:0] e_pc, input logic [2:0] e_sp, input logic e_err);
        exp_q.push_back(pack_exp(e_pc, e_sp, e_err));
        @(negedge clk);
        bus.pc_en   = en;
        bus.pc_op   = op;
        bus.pc_in   = in;
        bus.err_clr = clr;
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.pc_en   = 1'b0;
        bus.pc_op   = PC_HOLD;
        bus.pc_in   = 8'h00;
        bus.err_clr = 1'b0;

        #3;
        exp_q.push_back(pack_exp(8'h00, 3'd0, 1'b0));
        compare("reset");
        @(negedge clk);
        rst = 1'b0;

        // 1: increment, decrement through zero, wrap back
        for (int i = 1; i <= 5; i++) step("inc", 1'b1, PC_INC, 8'h00, 1'b0, 8'(i), 3'd0, 1'b0);
        for (int i = 4; i >= -1; i--) step("dec", 1'b1, PC_DEC, 8'h00, 1'b0, 8'(i), 3'd0, 1'b0);
        step("inc_wrap", 1'b1, PC_INC, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0);

        // 2: disabled ops hold, load, relative branches
        for (int i = 0; i < 4; i++) begin
            step("en0_hold", 1'b0, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 1'b0,
                 8'h00, 3'd0, 1'b0);
        end
        step("load_en0", 1'b0, PC_LOAD, 8'hAA, 1'b0, 8'h00, 3'd0, 1'b0);
        step("load", 1'b1, PC_LOAD, 8'hAA, 1'b0, 8'hAA, 3'd0, 1'b0);
        step("hold", 1'b1, PC_HOLD, 8'h55, 1'b0, 8'hAA, 3'd0, 1'b0);
        step("rel_neg", 1'b1, PC_REL, 8'hFE, 1'b0, 8'hA8, 3'd0, 1'b0);
        step("rel_wrap", 1'b1, PC_REL, 8'h7F, 1'b0, 8'h27, 3'd0, 1'b0);

        // 3: nested call/return
        step("load10", 1'b1, PC_LOAD, 8'h10, 1'b0, 8'h10, 3'd0, 1'b0);
        step("call40", 1'b1, PC_CALL, 8'h40, 1'b0, 8'h40, 3'd1, 1'b0);
        step("call80", 1'b1, PC_CALL, 8'h80, 1'b0, 8'h80, 3'd2, 1'b0);
        step("ret41", 1'b1, PC_RET, 8'h00, 1'b0, 8'h41, 3'd1, 1'b0);
        step("ret11", 1'b1, PC_RET, 8'h00, 1'b0, 8'h11, 3'd0, 1'b0);

        // 4: fill, overflow, clear, drain
        step("load00", 1'b1, PC_LOAD, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
        step("call10", 1'b1, PC_CALL, 8'h10, 1'b0, 8'h10, 3'd1, 1'b0);
        step("call20", 1'b1, PC_CALL, 8'h20, 1'b0, 8'h20, 3'd2, 1'b0);
        step("call30", 1'b1, PC_CALL, 8'h30, 1'b0, 8'h30, 3'd3, 1'b0);
        step("call40_full", 1'b1, PC_CALL, 8'h40, 1'b0, 8'h40, 3'd4, 1'b0);
        step("call_ovf", 1'b1, PC_CALL, 8'h50, 1'b0, 8'h40, 3'd4, 1'b1);
        step("err_clr", 1'b1, PC_HOLD, 8'h00, 1'b1, 8'h40, 3'd4, 1'b0);
        step("ret31", 1'b1, PC_RET, 8'h00, 1'b0, 8'h31, 3'd3, 1'b0);
        step("ret21", 1'b1, PC_RET, 8'h00, 1'b0, 8'h21, 3'd2, 1'b0);
        step("ret11b", 1'b1, PC_RET, 8'h00, 1'b0, 8'h11, 3'd1, 1'b0);
        step("ret01", 1'b1, PC_RET, 8'h00, 1'b0, 8'h01, 3'd0, 1'b0);

        // 5: underflow, clear while disabled, reserved op, set beats clear
        step("ret_unf", 1'b1, PC_RET, 8'h00, 1'b0, 8'h01, 3'd0, 1'b1);
        step("clr_en0", 1'b0, PC_INC, 8'h00, 1'b1, 8'h01, 3'd0, 1'b0);
        step("reserved", 1'b1, 3'b111, 8'hC3, 1'b0, 8'h01, 3'd0, 1'b0);
        step("ret_unf_clr", 1'b1, PC_RET, 8'h00, 1'b1, 8'h01, 3'd0, 1'b1);

        // 6: asynchronous reset between edges
        step("call_a", 1'b1, PC_CALL, 8'h10, 1'b0, 8'h10, 3'd1, 1'b1);
        step("call_b", 1'b1, PC_CALL, 8'h20, 1'b0, 8'h20, 3'd2, 1'b1);
        @(negedge clk);
        bus.pc_en = 1'b0;
        bus.pc_op = PC_HOLD;
        #2;
        rst = 1'b1;
        #1;
        exp_q.push_back(pack_exp(8'h00, 3'd0, 1'b0));
        compare("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        step("inc_after_rst", 1'b1, PC_INC, 8'h00, 1'b0, 8'h01, 3'd0, 1'b0);
        step("ret_after_rst", 1'b1, PC_RET, 8'h00, 1'b0, 8'h01, 3'd0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
